// File: rtl/serial_subtractor_n_bit_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Carries ovf only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_n_bit_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor_n_bit.sv
// Bit-serial N-bit subtractor: one bit per SHIFT cycle, LSB first, result latched on entry to DONE.
// Optional signed-overflow flag built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor_n_bit #(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_subtractor_n_bit_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          br_q, br_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;
    logic          ovf_q, ovf_d;
`endif

    logic          ai_s;
    logic          bi_s;
    logic          d_bit_s;
    logic          br_nxt_s;
    logic [N-1:0]  res_shift_s;

    // One full-subtractor step on the current LSBs of the operand shift registers.
    always_comb begin
        ai_s        = a_q[0];
        bi_s        = b_q[0];
        d_bit_s     = ai_s ^ bi_s ^ br_q;
        br_nxt_s    = (~ai_s & bi_s) | (~(ai_s ^ bi_s) & br_q);
        res_shift_s = {d_bit_s, res_q[N-1:1]};
    end

    // Next-state and datapath control; results load from the final step's combinational values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = {CW{1'b0}};
                    res_d   = {N{1'b0}};
                    state_d = SHIFT;
                    busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = bus.a[N-1];
                    b_msb_d = bus.b[N-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = {1'b0, a_q[N-1:1]};
                b_d   = {1'b0, b_q[N-1:1]};
                br_d  = br_nxt_s;
                res_d = res_shift_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    diff_d  = res_shift_s;
                    bout_d  = br_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q ^ b_msb_q) & (res_shift_s[N-1] ^ a_msb_q);
`endif
                end else begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {N{1'b0}};
            b_q     <= {N{1'b0}};
            br_q    <= 1'b0;
            res_q   <= {N{1'b0}};
            diff_q  <= {N{1'b0}};
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor_n_bit.sv
// Scoreboard bench for serial_subtractor_n_bit: directed cases plus randomized operations.
module tb_serial_subtractor_n_bit;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_n_bit_if #(.N(N)) bus ();
    serial_subtractor_n_bit #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned operands.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        exp_t e;
        int   r;
        r      = int'(a) - int'(b) - int'(bin);
        e.diff = r[N-1:0];
        e.bout = (int'(a) < (int'(b) + int'(bin)));
        e.ovf  = (a[N-1] != b[N-1]) && (e.diff[N-1] != a[N-1]);
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("diff", 32'(bus.diff), 32'(e.diff));
                check("bout", 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // mode 0: quiet inputs; 1: random inputs during SHIFT/DONE; 2: one start with a=all-ones in SHIFT
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin, input int mode);
        int          cyc;
        int          busy_cnt;
        exp_t        e;
        logic [31:0] r;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk); #1;
        e = model(a, b, bin);
        sb_q.push_back(e);
        bus.start = 1'b0;
        busy_cnt  = 0;
        cyc       = 0;
        while (bus.done !== 1'b1 && cyc < 4 * N) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (mode == 1) begin
                r = $urandom;
                bus.start = r[31];
                bus.bin   = r[30];
                bus.a     = r[N-1:0];
                bus.b     = r[2*N-1:N];
            end else if (mode == 2) begin
                bus.start = (cyc == 1);
                bus.a     = {N{1'b1}};
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("done_latency", 32'(cyc), 32'(N));
        check("busy_cycles", 32'(busy_cnt), 32'(N));
        if (mode == 1) begin
            r = $urandom;
            bus.start = r[31];
            bus.a     = r[N-1:0];
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_width", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("result_hold", 32'(bus.diff), 32'(e.diff));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_diff"}, 32'(bus.diff), 32'd0);
        check({tag, "_bout"}, 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
    endtask

    initial begin
        int          done_seen;
        logic [31:0] r;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = {N{1'b0}};
        bus.b     = {N{1'b0}};
        bus.bin   = 1'b0;
        #1;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(4'b0101, 4'b0011, 1'b1, 0);
        run_op(4'b0001, 4'b0010, 1'b0, 0);
        run_op(4'b0000, 4'b1111, 1'b1, 0);
        run_op(4'b1001, 4'b0110, 1'b0, 2);

        // Reset two cycles into SHIFT: outputs clear at once and the operation is dropped.
        bus.start = 1'b1;
        bus.a     = 4'b0111;
        bus.b     = 4'b0001;
        bus.bin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'd0);
        run_op(4'b1010, 4'b0101, 1'b0, 0);

`ifdef SERIAL_SUB_OVF_EN
        run_op(4'b1000, 4'b0001, 1'b0, 0);
        run_op(4'b0011, 4'b0001, 1'b0, 0);
`endif

        run_op({N{1'b1}}, {N{1'b1}}, 1'b1, 0);
        run_op({N{1'b1}}, {N{1'b0}}, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            run_op(r[N-1:0], r[2*N-1:N], r[16], (r[20] ? 1 : 0));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
